// File: rtl/bram_sched_pkg.sv
// Shared types and widths for the BRAM access scheduler.
// The BRAM read port takes byte addresses, and the word index is the byte address shifted right by BYTE_SHIFT.
package bram_sched_pkg;

  localparam int DATA_W     = 32;
  localparam int WR_AW      = 7;
  localparam int RD_AW      = 20;
  localparam int BYTE_SHIFT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/bram_access_sched_if.sv
// Bundles the loader write stream, the burst command, the return stream and the BRAM port.
// master is the scheduler side, and slave is the loader/consumer/BRAM side.
interface bram_access_sched_if
  import bram_sched_pkg::*;
#(
  parameter int DATA_W = bram_sched_pkg::DATA_W,
  parameter int WR_AW  = bram_sched_pkg::WR_AW,
  parameter int RD_AW  = bram_sched_pkg::RD_AW,
  parameter int LEN_W  = 8,
  parameter int STR_W  = 4
);
  logic              wr_valid;
  logic              wr_ready;
  logic [WR_AW-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              rd_start;
  logic [RD_AW-1:0]  rd_base;
  logic [LEN_W-1:0]  rd_len;
  logic [STR_W-1:0]  rd_stride;
  logic              rd_busy;
  logic              rd_done;

  logic              rd_data_valid;
  logic              rd_data_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_last;

  logic              bram_wr_rd_en;
  logic [WR_AW-1:0]  bram_wr_addr;
  logic [RD_AW-1:0]  bram_rd_addr;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;

  modport master (
    input  wr_valid, wr_addr, wr_data,
    input  rd_start, rd_base, rd_len, rd_stride,
    input  rd_data_ready, bram_dout,
    output wr_ready, rd_busy, rd_done,
    output rd_data_valid, rd_data, rd_data_last,
    output bram_wr_rd_en, bram_wr_addr, bram_rd_addr, bram_din
  );

  modport slave (
    output wr_valid, wr_addr, wr_data,
    output rd_start, rd_base, rd_len, rd_stride,
    output rd_data_ready, bram_dout,
    input  wr_ready, rd_busy, rd_done,
    input  rd_data_valid, rd_data, rd_data_last,
    input  bram_wr_rd_en, bram_wr_addr, bram_rd_addr, bram_din
  );
endinterface

// File: rtl/bram_ret_fifo.sv
// Small return FIFO holding {last, data} beats between BRAM capture and the consumer.
// The caller guarantees that it never pushes when the FIFO is full and never pops when it is empty.
module bram_ret_fifo
  import bram_sched_pkg::*;
#(
  parameter int DW    = 33,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [AW-1:0]             wptr_q, rptr_q;
  logic [CW-1:0]             cnt_q;
  logic [DEPTH-1:0][DW-1:0]  slot_data;

  // Payload slots carry no reset, because the pointers alone decide what is valid.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [DW-1:0] data_q;
    always_ff @(posedge clk) begin
      if (push_i && (wptr_q == AW'(gi))) data_q <= din_i;
    end
    assign slot_data[gi] = data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      if (push_i && !pop_i)      cnt_q <= cnt_q + CW'(1);
      else if (pop_i && !push_i) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign dout_o  = slot_data[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/bram_access_sched.sv
// Shares the single-port BRAM between a loader write stream and a strided burst reader.
// Reads are credit-limited so that every beat in flight always has room in the return FIFO.
module bram_access_sched
  import bram_sched_pkg::*;
#(
  parameter int DATA_W = bram_sched_pkg::DATA_W,
  parameter int WR_AW  = bram_sched_pkg::WR_AW,
  parameter int RD_AW  = bram_sched_pkg::RD_AW,
  parameter int LEN_W  = 8,
  parameter int STR_W  = 4,
  parameter int FIFO_D = 2
) (
  input logic               clk,
  input logic               rst_n,
  bram_access_sched_if.master bus
);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_BURST = BURST;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;
  localparam int         CW      = $clog2(FIFO_D) + 1;

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic [STR_W-1:0]  stride_q, stride_d;
  logic [RD_AW-1:0]  addr_q, addr_d;
  logic [RD_AW-1:0]  rd_addr_q;
  logic              inflight_q, inflight_last_q, rr_q;

  logic              fifo_empty, head_last, pop, rd_req, grant_w, grant_r;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       occ;
  logic [DATA_W-1:0] head_data;
  logic [RD_AW-1:0]  step;

  assign step = RD_AW'({stride_q, {BYTE_SHIFT{1'b0}}});
  assign pop  = !fifo_empty && bus.rd_data_ready;

  // Occupancy after this cycle's pop. A beat that is in flight already owns a slot.
  assign occ    = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign rd_req = (state_q == S_BURST) && (cnt_q < len_q) && (occ < (CW+1)'(FIFO_D));

  // rr_q set means the write side wins the next contested cycle.
  assign grant_w = bus.wr_valid && (!rd_req || rr_q);
  assign grant_r = rd_req && (!bus.wr_valid || !rr_q);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    stride_d = stride_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.rd_start) begin
          len_d    = bus.rd_len;
          stride_d = bus.rd_stride;
          addr_d   = bus.rd_base;
          cnt_d    = '0;
          state_d  = (bus.rd_len != '0) ? S_BURST : S_DONE;
        end
      end
      S_BURST: if (cnt_q == len_q) state_d = S_DRAIN;
      S_DRAIN: if (!inflight_q && fifo_empty) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (grant_r) begin
      cnt_d  = cnt_q + LEN_W'(1);
      addr_d = addr_q + step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      len_q           <= '0;
      stride_q        <= '0;
      cnt_q           <= '0;
      addr_q          <= '0;
      rd_addr_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rr_q            <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      stride_q        <= stride_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      inflight_q      <= grant_r;
      inflight_last_q <= grant_r && (cnt_q == len_q - LEN_W'(1));
      if (grant_r) rd_addr_q <= addr_q;
      if (bus.wr_valid && rd_req) rr_q <= !rr_q;
    end
  end

  // Capture happens only on the cycle after a read issue, so the zero returned after a write is never seen.
  bram_ret_fifo #(
    .DW    (DATA_W + 1),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .din_i   ({inflight_last_q, bus.bram_dout}),
    .pop_i   (pop),
    .dout_o  ({head_last, head_data}),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign bus.wr_ready      = grant_w;
  assign bus.bram_wr_rd_en = grant_w;
  assign bus.bram_wr_addr  = grant_w ? bus.wr_addr : '0;
  assign bus.bram_din      = grant_w ? bus.wr_data : '0;
  assign bus.bram_rd_addr  = grant_r ? addr_q : rd_addr_q;

  assign bus.rd_busy       = (state_q != S_IDLE);
  assign bus.rd_done       = (state_q == S_DONE);
  assign bus.rd_data_valid = !fifo_empty;
  assign bus.rd_data       = fifo_empty ? '0 : head_data;
  assign bus.rd_data_last  = !fifo_empty && head_last;
endmodule
